// File: rtl/hex_keypad_scan.sv
// ============================================================================
//  Module   : hex_keypad_scan
//  Purpose  : 4x4 matrix keypad scanner with debounce and a 4-digit entry shift register.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module hex_keypad_scan #(
  parameter int SCAN_DIV = 8192,
  parameter int DEBOUNCE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  rows,
  output logic [3:0]  cols,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic        key_held,
  output logic [15:0] entry
);

  localparam int                 c_div_w    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(SCAN_DIV - 1);
  localparam logic [3:0]         c_db_max   = 4'(DEBOUNCE);
  localparam logic [4:0]         c_none     = 5'h10;

  typedef enum logic [0:0] {
    RELEASED = 1'b0,
    PRESSED  = 1'b1
  } state_t;

  logic [3:0]         r_rows_meta;
  logic [3:0]         r_rows_sync;
  logic [c_div_w-1:0] r_div;
  logic [1:0]         r_col_idx;
  logic [11:0]        r_map;
  logic [4:0]         r_prev;
  logic [3:0]         r_db_cnt;
  state_t             r_state;
  state_t             w_state_next;
  logic               r_key_valid;
  logic [3:0]         r_key_code;
  logic [15:0]        r_entry;

  logic        w_sample;
  logic        w_frame_end;
  logic [15:0] w_pressed;
  logic [4:0]  w_hits;
  logic [3:0]  w_code;
  logic [4:0]  w_result;
  logic [3:0]  w_cnt_next;
  logic        w_stable;
  logic        w_accept;

  assign w_sample    = (r_div == c_div_last);
  assign w_frame_end = w_sample && (r_col_idx == 2'd3);

  // Map bit index is col*4 + row; the last column comes straight from the synchroniser.
  assign w_pressed = ~{r_rows_sync, r_map};

  always_comb begin
    w_hits = 5'd0;
    w_code = 4'd0;
    for (int b = 0; b < 16; b++) begin
      if (w_pressed[b]) begin
        w_hits = w_hits + 5'd1;
        w_code = {b[1:0], b[3:2]};
      end
    end
  end

  assign w_result   = (w_hits == 5'd1) ? {1'b0, w_code} : c_none;
  assign w_cnt_next = (w_result != r_prev) ? 4'd1 :
                      (r_db_cnt == c_db_max) ? r_db_cnt : r_db_cnt + 4'd1;
  assign w_stable   = (w_cnt_next == c_db_max);

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    if (w_frame_end && w_stable) begin
      case (r_state)
        RELEASED: begin
          if (!w_result[4]) begin
            w_state_next = PRESSED;
            w_accept     = 1'b1;
          end
        end
        PRESSED: begin
          if (w_result[4]) begin
            w_state_next = RELEASED;
          end
        end
        default: w_state_next = RELEASED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RELEASED;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rows_meta <= 4'hF;
      r_rows_sync <= 4'hF;
      r_div       <= '0;
      r_col_idx   <= 2'd0;
      r_map       <= 12'hFFF;
      r_prev      <= c_none;
      r_db_cnt    <= 4'd0;
      r_key_valid <= 1'b0;
      r_key_code  <= 4'd0;
      r_entry     <= 16'h0000;
    end else begin
      r_rows_meta <= rows;
      r_rows_sync <= r_rows_meta;
      r_key_valid <= w_accept;

      if (w_sample) begin
        r_div     <= '0;
        r_col_idx <= r_col_idx + 2'd1;
        case (r_col_idx)
          2'd0:    r_map[3:0]  <= r_rows_sync;
          2'd1:    r_map[7:4]  <= r_rows_sync;
          2'd2:    r_map[11:8] <= r_rows_sync;
          default: r_map       <= r_map;
        endcase
      end else begin
        r_div <= r_div + c_div_w'(1);
      end

      if (w_frame_end) begin
        r_prev   <= w_result;
        r_db_cnt <= w_cnt_next;
      end

      if (w_accept) begin
        r_key_code <= w_result[3:0];
        r_entry    <= {r_entry[11:0], w_result[3:0]};
      end
    end
  end

  assign cols      = ~(4'b0001 << r_col_idx);
  assign key_valid = r_key_valid;
  assign key_code  = r_key_code;
  assign key_held  = (r_state == PRESSED);
  assign entry     = r_entry;

endmodule

`default_nettype wire

// File: tb/tb_hex_keypad_scan.sv
// ============================================================================
//  Module   : tb_hex_keypad_scan
//  Purpose  : Directed bench for hex_keypad_scan with a behavioural keypad matrix.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_hex_keypad_scan;

  localparam int c_frame = 16;

  logic        clk;
  logic        rst;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_held;
  logic [15:0] entry;

  logic [15:0] keys;

  int n_tests;
  int n_fail;
  int pulse_cnt;
  int consec_cnt;
  logic prev_kv;

  hex_keypad_scan #(.SCAN_DIV(4), .DEBOUNCE(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .rows      (rows),
    .cols      (cols),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_held  (key_held),
    .entry     (entry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Key bit index equals its code: row*4 + col.
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !cols[c]) rows[r] = 1'b0;
  end

  always @(negedge clk) begin
    if (key_valid) begin
      pulse_cnt = pulse_cnt + 1;
      if (prev_kv) consec_cnt = consec_cnt + 1;
    end
    prev_kv = key_valid;
  end

  typedef struct {
    logic [15:0] keys;
    int          frames;
    int          pulses;
    logic [3:0]  code;
    logic [15:0] entry;
    logic        held;
  } vec_t;

  vec_t vt [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_negs(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic measure_latency(output int lat);
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (key_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    int p0;
    int lat;
    int held_seen;

    vt[0]  = '{16'h0002, 3, 1, 4'h1, 16'h0061, 1'b1};
    vt[1]  = '{16'h0000, 3, 0, 4'h1, 16'h0061, 1'b0};
    vt[2]  = '{16'h0004, 3, 1, 4'h2, 16'h0612, 1'b1};
    vt[3]  = '{16'h0000, 3, 0, 4'h2, 16'h0612, 1'b0};
    vt[4]  = '{16'h0008, 3, 1, 4'h3, 16'h6123, 1'b1};
    vt[5]  = '{16'h0000, 3, 0, 4'h3, 16'h6123, 1'b0};
    vt[6]  = '{16'h0400, 3, 1, 4'hA, 16'h123A, 1'b1};
    vt[7]  = '{16'h0000, 3, 0, 4'hA, 16'h123A, 1'b0};
    vt[8]  = '{16'h8000, 3, 1, 4'hF, 16'h23AF, 1'b1};
    vt[9]  = '{16'h0000, 3, 0, 4'hF, 16'h23AF, 1'b0};
    vt[10] = '{16'h8001, 4, 0, 4'hF, 16'h23AF, 1'b0};
    vt[11] = '{16'h0000, 3, 0, 4'hF, 16'h23AF, 1'b0};

    n_tests = 0; n_fail = 0; pulse_cnt = 0; consec_cnt = 0; prev_kv = 1'b0;
    keys = 16'h0000;
    rst  = 1'b1;
    wait_negs(3);
    chk("rst_cols", 32'(cols), 32'hE);
    chk("rst_valid", 32'(key_valid), 32'h0);
    chk("rst_code", 32'(key_code), 32'h0);
    chk("rst_held", 32'(key_held), 32'h0);
    chk("rst_entry", 32'(entry), 32'h0);
    rst = 1'b0;
    pulse_cnt = 0;

    // Idle scan: column drive walks with a 4-clock dwell.
    for (int i = 0; i < 7 * c_frame; i++) begin
      chk("idle_cols", 32'(cols), 32'(~(4'b0001 << ((i / 4) % 4)) & 4'hF));
      @(negedge clk);
    end
    chk("idle_pulses", 32'(pulse_cnt), 32'd0);
    chk("idle_entry", 32'(entry), 32'h0);

    // Single key 6, held for 5 frames.
    p0 = pulse_cnt;
    keys = 16'h0040;
    measure_latency(lat);
    chk("k6_latency", 32'(lat), 32'd32);
    if (lat > 0) wait_negs(5 * c_frame - lat);
    chk("k6_pulses", 32'(pulse_cnt - p0), 32'd1);
    chk("k6_code", 32'(key_code), 32'h6);
    chk("k6_entry", 32'(entry), 32'h0006);
    chk("k6_held", 32'(key_held), 32'h1);
    keys = 16'h0000;
    wait_negs(3 * c_frame);
    chk("k6_release", 32'(key_held), 32'h0);

    // Bounce on alternate frames, then release.
    p0 = pulse_cnt;
    held_seen = 0;
    for (int f = 0; f < 9; f++) begin
      keys = (f < 6 && (f % 2 == 0)) ? 16'h0200 : 16'h0000;
      for (int k = 0; k < c_frame; k++) begin
        @(negedge clk);
        if (key_held) held_seen = 1;
      end
    end
    chk("bounce_pulses", 32'(pulse_cnt - p0), 32'd0);
    chk("bounce_held", 32'(held_seen), 32'd0);

    for (int v = 0; v < 12; v++) begin
      p0 = pulse_cnt;
      keys = vt[v].keys;
      wait_negs(vt[v].frames * c_frame);
      chk($sformatf("vec%0d_pulses", v), 32'(pulse_cnt - p0), 32'(vt[v].pulses));
      chk($sformatf("vec%0d_code", v), 32'(key_code), 32'(vt[v].code));
      chk($sformatf("vec%0d_entry", v), 32'(entry), 32'(vt[v].entry));
      chk($sformatf("vec%0d_held", v), 32'(key_held), 32'(vt[v].held));
    end

    // Key 5 accepted, then a mid-frame reset with the key still down.
    keys = 16'h0020;
    wait_negs(4 * c_frame);
    chk("k5_code", 32'(key_code), 32'h5);
    chk("k5_entry", 32'(entry), 32'h3AF5);
    wait_negs(7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_cols", 32'(cols), 32'hE);
    chk("mrst_valid", 32'(key_valid), 32'h0);
    chk("mrst_code", 32'(key_code), 32'h0);
    chk("mrst_held", 32'(key_held), 32'h0);
    chk("mrst_entry", 32'(entry), 32'h0);
    measure_latency(lat);
    chk("mrst_latency", 32'(lat), 32'd32);
    @(negedge clk);
    chk("mrst_k5_code", 32'(key_code), 32'h5);
    chk("mrst_k5_entry", 32'(entry), 32'h0005);
    chk("mrst_k5_held", 32'(key_held), 32'h1);

    keys = 16'h0000;
    wait_negs(3 * c_frame);
    chk("final_held", 32'(key_held), 32'h0);
    chk("no_consecutive_valid", 32'(consec_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hex_keypad_scan.md
Name: hex_keypad_scan

Overview:
- Scans a 4x4 matrix keypad and emits debounced hex key codes.
- Input-side counterpart of the multiplexed hex display path: it drives columns one at a time, reads rows, debounces, and reports each new keypress once.
- Also shifts accepted digits into a 16-bit entry register that can feed the display data bus directly, so typed digits appear on the 4-digit display.

Parameters:
- SCAN_DIV, 8192, clk cycles per column dwell; must be >= 4.
- DEBOUNCE, 4, consecutive identical scan frames required to accept a press or a release; must be 1..15.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- rows  input  4  keypad row lines, active-low, externally pulled up, asynchronous.
- cols  output  4  keypad column drive, active-low, exactly one bit low at all times.
- key_valid  output  1  one-cycle pulse when a new debounced press is accepted.
- key_code  output  4  code of the last accepted key; held until the next accept.
- key_held  output  1  high while the accepted key is still debounced-pressed.
- entry  output  16  last four accepted codes; the newest is in [3:0].

Behaviour:
- Reset (rst=1 at a clk edge) clears all state: div counter 0, col_idx 0, cols=4'b1110, key_valid=0, key_code=0, key_held=0, entry=16'h0000, debounce count 0, FSM=RELEASED, candidate=NONE. Reset mid-frame discards the partial frame; scanning restarts at column 0.
- Row synchroniser:
  - rows pass through a 2-flop synchroniser before any use.
  - A pressed key is a row bit reading 0.
- Scan timing:
  - div counter counts 0..SCAN_DIV-1 and wraps.
  - cols = ~(4'b0001 << col_idx).
  - On the cycle where div == SCAN_DIV-1: the synchronised rows are captured as the map nibble for col_idx, and col_idx increments modulo 4.
  - Sampling at the end of the dwell guarantees that the synchroniser has settled.
- Frame: one frame is the four column samples, SCAN_DIV*4 clocks long. The frame ends on the sample cycle where col_idx==3.
- Frame result, evaluated at frame end:
  - Exactly one pressed bit in the 16-bit map gives a candidate code of row*4 + col (row 0 = rows[0], col 0 = cols[0]).
  - Zero pressed bits give NONE.
  - Two or more pressed bits (ghosting or multi-key) give NONE.
- Debounce:
  - If the frame result equals the previous frame result, the count increments, saturating at DEBOUNCE.
  - Otherwise the count resets to 1 and the previous result is updated.
  - The result is stable when count == DEBOUNCE.
- FSM:
  - RELEASED -> PRESSED when the result is stable and is a code.
    - On the cycle after that frame end: key_valid=1 for exactly one cycle, key_code <= code, entry <= {entry[11:0], code}.
    - key_held=1 from that same cycle.
  - PRESSED -> RELEASED when the result is stable NONE.
    - key_held falls on the cycle after that frame end.
  - In PRESSED, a stable different code does not produce a pulse. A full stable release is required before the next accept (no rollover).
- Latency: the accept pulse comes DEBOUNCE frames after the first frame showing the key, plus 1 clk after the final frame-end sample, plus 2 clk of synchroniser latency before that sample.
- Wrap-around:
  - entry shifts without bound; the oldest digit drops.
  - key_code overwrites.
  - The div and col_idx counters wrap silently.
- key_valid is never high on two consecutive cycles.

Test Plan (SCAN_DIV=4, DEBOUNCE=2, frame = 16 clk):
- Reset, then idle with rows=4'hF for 100 clk -> cols cycles 1110,1101,1011,0111 with a 4-clk dwell each; key_valid never 1; entry=16'h0000.
- Hold key row1/col2 (rows[1]=0 only while cols[2]=0) for 5 frames -> exactly one key_valid pulse, within 2 frames + 1 clk of the first full frame; key_code=4'h6; entry=16'h0006; key_held=1.
- Bounce: toggle the key on alternate frames for 6 frames, then release -> no key_valid; key_held stays 0.
- Press and release keys 1, 2, 3, A, then F (each held 3 frames, released 3 frames) -> five pulses; final entry=16'h23AF; key_code=4'hF; key_held=0 after the last release.
- Press row0/col0 and row3/col3 simultaneously for 4 frames -> no pulse (ghost reject).
- Hold key 5 for 4 frames, assert rst for 1 clk mid-frame, keep key 5 held -> all outputs return to reset values; a fresh key_valid with key_code=4'h5 follows after 2 full frames; entry=16'h0005.
